// File: rtl/traffic_pkg.sv
// Shared types for the intersection sequencer.
//   phase_t : phase encoding, also driven out on the phase debug port
//   lamp_t  : one-hot lamp code {red,yellow,green}
package traffic_pkg;

   typedef enum logic [2:0] {
      A_GRN  = 3'd0,
      A_YEL  = 3'd1,
      RED_AB = 3'd2,
      B_GRN  = 3'd3,
      B_YEL  = 3'd4,
      RED_BA = 3'd5
   } phase_t;

   typedef logic [2:0] lamp_t;

   localparam lamp_t LAMP_R = 3'b100;
   localparam lamp_t LAMP_Y = 3'b010;
   localparam lamp_t LAMP_G = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter for the time spent in the current phase.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear (wins over tick), pulsed on every phase change
//   tick       : timebase strobe, one increment per strobe
//   cnt        : ticks elapsed in the phase, sticks at all-ones
module phase_timer #(
   parameter int TW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          tick,
   output logic [TW-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (tick && (cnt != {TW{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/phase_sequencer.sv
// Timed two-street intersection sequencer with min/max green, yellow and
// all-red timing, pedestrian walk requests and emergency preemption.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   tick           : 1-cycle timebase strobe
//   ta, tb         : traffic present on street A / B (level)
//   ped_a, ped_b   : walk request pulses, latched internally
//   emg, emg_dir   : preemption active, preempted direction (0=A, 1=B)
//   la, lb         : lamp drivers, one-hot {red,yellow,green}
//   walk_a, walk_b : walk lamps
//   phase          : current phase code
module phase_sequencer
   import traffic_pkg::*;
#(
   parameter int TW        = 6,
   parameter int MIN_GREEN = 5,
   parameter int MAX_GREEN = 20,
   parameter int YELLOW    = 3,
   parameter int ALL_RED   = 1,
   parameter int WALK      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       ta,
   input  logic       tb,
   input  logic       ped_a,
   input  logic       ped_b,
   input  logic       emg,
   input  logic       emg_dir,
   output lamp_t      la,
   output lamp_t      lb,
   output logic       walk_a,
   output logic       walk_b,
   output logic [2:0] phase
);

   phase_t        cur, nxt;
   logic [TW-1:0] timer;
   logic [TW:0]   el;
   logic          ped_a_q, ped_b_q;
   logic          served_a, served_b;
   logic          emg_a, emg_b, dem_a, dem_b;
   logic          enter_a, enter_b;

   // One extra bit so the elapsed count never wraps at saturation.
   assign el    = {1'b0, timer} + {{TW{1'b0}}, 1'b1};

   assign emg_a = emg & ~emg_dir;
   assign emg_b = emg &  emg_dir;
   assign dem_a = ta | ped_a_q | emg_a;
   assign dem_b = tb | ped_b_q | emg_b;

   assign enter_a = (nxt == A_GRN) && (cur != A_GRN);
   assign enter_b = (nxt == B_GRN) && (cur != B_GRN);

   phase_timer #(.TW(TW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (nxt != cur),
      .tick  (tick),
      .cnt   (timer)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         cur <= A_GRN;
      else
         cur <= nxt;
   end

   // Next-state logic. Yellow and all-red are never shortened, even by
   // preemption; only greens react to emg.
   always_comb begin
      nxt = cur;
      case (cur)
         A_GRN: begin
            if (emg_b ||
                (tick && !emg_a && dem_b &&
                 ((el >= (TW+1)'(MIN_GREEN) && !ta) || el >= (TW+1)'(MAX_GREEN))))
               nxt = A_YEL;
         end
         A_YEL:  if (tick && el == (TW+1)'(YELLOW))  nxt = RED_AB;
         RED_AB: if (tick && el == (TW+1)'(ALL_RED)) nxt = B_GRN;
         B_GRN: begin
            if (emg_a ||
                (tick && !emg_b && dem_a &&
                 ((el >= (TW+1)'(MIN_GREEN) && !tb) || el >= (TW+1)'(MAX_GREEN))))
               nxt = B_YEL;
         end
         B_YEL:  if (tick && el == (TW+1)'(YELLOW))  nxt = RED_BA;
         RED_BA: if (tick && el == (TW+1)'(ALL_RED)) nxt = A_GRN;
         default: nxt = A_GRN;
      endcase
   end

   // Output decode from the registered phase; emg only gates the walk lamps.
   always_comb begin
      la     = LAMP_R;
      lb     = LAMP_R;
      walk_a = 1'b0;
      walk_b = 1'b0;
      case (cur)
         A_GRN: la = LAMP_G;
         A_YEL: la = LAMP_Y;
         B_GRN: lb = LAMP_G;
         B_YEL: lb = LAMP_Y;
         default: ;
      endcase
      if (cur == A_GRN && timer < TW'(WALK) && served_a && !emg) walk_a = 1'b1;
      if (cur == B_GRN && timer < TW'(WALK) && served_b && !emg) walk_b = 1'b1;
   end

   assign phase = cur;

   // Ped latches. Entering the green consumes the latch into the served flag;
   // a pulse on that entry cycle is dropped, and pulses during walk are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         ped_a_q  <= 1'b0;
         ped_b_q  <= 1'b0;
         served_a <= 1'b0;
         served_b <= 1'b0;
      end else begin
         if (enter_a) begin
            ped_a_q  <= 1'b0;
            served_a <= ped_a_q;
         end else if (ped_a && !walk_a) begin
            ped_a_q  <= 1'b1;
         end
         if (enter_b) begin
            ped_b_q  <= 1'b0;
            served_b <= ped_b_q;
         end else if (ped_b && !walk_b) begin
            ped_b_q  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: expected phase/walk per tick is pushed
// to a scoreboard queue and popped when the DUT output is sampled.
module tb_phase_sequencer;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       reset, tick, ta, tb, ped_a, ped_b, emg, emg_dir;
   lamp_t      la, lb;
   logic       walk_a, walk_b;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] ph;
      logic       wa;
      logic       wb;
   } exp_t;

   exp_t sb[$];

   phase_sequencer dut (
      .clk(clk), .reset(reset), .tick(tick), .ta(ta), .tb(tb),
      .ped_a(ped_a), .ped_b(ped_b), .emg(emg), .emg_dir(emg_dir),
      .la(la), .lb(lb), .walk_a(walk_a), .walk_b(walk_b), .phase(phase)
   );

   always #5 clk = ~clk;

   function automatic lamp_t exp_la(input logic [2:0] ph);
      case (ph)
         3'd0:    return 3'b001;
         3'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic lamp_t exp_lb(input logic [2:0] ph);
      case (ph)
         3'd3:    return 3'b001;
         3'd4:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   task automatic push_n(input logic [2:0] ph, input int n, input logic wa, input logic wb);
      exp_t e;
      e.ph = ph; e.wa = wa; e.wb = wb;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   // At most one street may be non-red at any time.
   task automatic inv();
      checks++;
      assert (!(la != 3'b100 && lb != 3'b100))
      else begin
         errors++;
         $error("FAIL invariant la=%b lb=%b required one red", la, lb);
      end
   endtask

   task automatic cmp(input string tag);
      exp_t e;
      logic [10:0] obs, want;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty, observed phase=%0d", tag, phase);
         return;
      end
      e    = sb.pop_front();
      want = {e.ph, exp_la(e.ph), exp_lb(e.ph), e.wa, e.wb};
      obs  = {phase, la, lb, walk_a, walk_b};
      assert (obs === want)
      else begin
         errors++;
         $error("FAIL %s {ph,la,lb,wa,wb} observed=%b expected=%b", tag, obs, want);
      end
   endtask

   // One tick period = 4 clocks; sample right after the tick edge.
   task automatic step(input string tag);
      @(negedge clk) tick = 1'b1; inv();
      @(negedge clk) tick = 1'b0; inv();
      cmp(tag);
      @(negedge clk) inv();
      @(negedge clk) inv();
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic clk_chk(input string tag);
      @(negedge clk) inv();
      cmp(tag);
   endtask

   task automatic do_reset(input logic a, input logic b);
      @(negedge clk);
      reset = 1'b1; tick = 1'b0; ped_a = 1'b0; ped_b = 1'b0; emg = 1'b0; emg_dir = 1'b0;
      @(negedge clk);
      reset = 1'b0; ta = a; tb = b;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; ta = 1'b0; tb = 1'b0;
      ped_a = 1'b0; ped_b = 1'b0; emg = 1'b0; emg_dir = 1'b0;
      repeat (2) @(negedge clk);

      // 1: A rests with no cross demand
      do_reset(1'b1, 1'b0);
      push_n(0, 1, 0, 0); cmp("t1_reset");
      push_n(0, 40, 0, 0); run(40, "t1_rest");

      // 2: B demand only, MIN_GREEN exit then yellow / all-red
      do_reset(1'b0, 1'b1);
      push_n(0, 4, 0, 0); push_n(1, 3, 0, 0); push_n(2, 1, 0, 0); push_n(3, 3, 0, 0);
      run(11, "t2_min");

      // 3: both streets busy, MAX_GREEN alternation
      do_reset(1'b1, 1'b1);
      push_n(0, 19, 0, 0); push_n(1, 3, 0, 0); push_n(2, 1, 0, 0);
      push_n(3, 20, 0, 0); push_n(4, 3, 0, 0); push_n(5, 1, 0, 0);
      push_n(0, 20, 0, 0); push_n(1, 2, 0, 0);
      run(69, "t3_max");

      // 4: ped_b pulse at tick 2, served with walk_b in the B green
      do_reset(1'b1, 1'b0);
      push_n(0, 1, 0, 0); run(1, "t4_pre");
      @(negedge clk) tick = 1'b1; ped_b = 1'b1; inv();
      @(negedge clk) tick = 1'b0; ped_b = 1'b0; inv();
      push_n(0, 1, 0, 0); cmp("t4_ped");
      @(negedge clk) inv();
      @(negedge clk) inv();
      push_n(0, 17, 0, 0); push_n(1, 3, 0, 0); push_n(2, 1, 0, 0);
      push_n(3, 4, 0, 1); push_n(3, 1, 0, 0);
      push_n(4, 3, 0, 0); push_n(5, 1, 0, 0);
      push_n(0, 25, 0, 0);   // latch consumed: A rests again
      run(55, "t4_walk");

      // 5: emergency preemption toward B
      do_reset(1'b1, 1'b0);
      push_n(0, 1, 0, 0); run(1, "t5_pre");
      emg = 1'b1; emg_dir = 1'b1;
      push_n(1, 1, 0, 0); clk_chk("t5_emg_now");
      ped_b = 1'b1;
      @(negedge clk) ped_b = 1'b0; inv();
      push_n(1, 2, 0, 0); push_n(2, 1, 0, 0); push_n(3, 26, 0, 0);
      run(29, "t5_hold");
      emg = 1'b0;
      push_n(4, 1, 0, 0); run(1, "t5_release");

      // 6: reset pulse during B_YEL
      do_reset(1'b0, 1'b1);
      push_n(0, 4, 0, 0); push_n(1, 3, 0, 0); push_n(2, 1, 0, 0); push_n(3, 1, 0, 0);
      run(9, "t6_to_b");
      ta = 1'b1; tb = 1'b0;
      push_n(3, 4, 0, 0); push_n(4, 1, 0, 0);
      run(5, "t6_byel");
      ped_a = 1'b1;
      @(negedge clk) ped_a = 1'b0; reset = 1'b1; inv();
      push_n(0, 1, 0, 0); clk_chk("t6_reset");
      checks++;
      assert (dut.timer === '0)
      else begin errors++; $error("FAIL t6_timer observed=%0d expected=0", dut.timer); end
      checks++;
      assert (dut.ped_a_q === 1'b0)
      else begin errors++; $error("FAIL t6_ped_a observed=%b expected=0", dut.ped_a_q); end
      reset = 1'b0; ta = 1'b0; tb = 1'b1;
      push_n(0, 4, 0, 0); push_n(1, 1, 0, 0);
      run(5, "t6_after");

      checks++;
      assert (sb.size() == 0)
      else begin errors++; $error("FAIL sb_drain observed=%0d expected=0", sb.size()); end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
